// File: rtl/infix_to_postfix_pkg.sv
// Shared definitions for the infix-to-postfix converter: ASCII character
// codes, the default malformed-expression token, operator precedence and
// the controller state encoding.
package infix_to_postfix_pkg;

  localparam logic [6:0] CH_0     = 7'h30;
  localparam logic [6:0] CH_9     = 7'h39;
  localparam logic [6:0] CH_PLUS  = 7'h2B;
  localparam logic [6:0] CH_MINUS = 7'h2D;
  localparam logic [6:0] CH_MUL   = 7'h2A;
  localparam logic [6:0] CH_LP    = 7'h28;
  localparam logic [6:0] CH_RP    = 7'h29;
  localparam logic [6:0] CH_EQ    = 7'h3D;

  localparam logic [6:0] ERR_TOK_DEFAULT = 7'h7F;

  typedef enum logic [3:0] {
    IDLE,
    DECODE,
    EMIT_OPND,
    POP_OPS,
    PUSH,
    CLOSE,
    FLUSH,
    EMIT_END,
    DRAIN_ERR
  } state_t;

  // '(' and anything else rank 0, so it never pops under an operator.
  function automatic logic [1:0] prec(input logic [6:0] ch);
    case (ch)
      CH_MUL:            prec = 2'd2;
      CH_PLUS, CH_MINUS: prec = 2'd1;
      default:           prec = 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/infix_to_postfix_if.sv
// Character-in / token-out handshake bundle of the converter.
//   en, variable : character strobe and ASCII code (upstream -> block)
//   req          : block ready for one character
//   tok_req      : downstream ready for one token
//   tok_en, tok  : token strobe and postfix token (block -> downstream)
//   err          : malformed expression in progress
interface infix_to_postfix_if;
  logic       en;
  logic [6:0] variable;
  logic       req;
  logic       tok_req;
  logic       tok_en;
  logic [6:0] tok;
  logic       err;

  modport master (output en, variable, tok_req, input req, tok_en, tok, err);
  modport slave  (input en, variable, tok_req, output req, tok_en, tok, err);
endinterface

// File: rtl/infix_to_postfix_op_stack.sv
// Operator LIFO, 7-bit entries.
//   push/pop/din : synchronous push or pop (never both in one cycle)
//   clr          : synchronous empty
//   top          : entry at top of stack (undefined when empty)
//   empty/full   : occupancy flags
module infix_to_postfix_op_stack #(
  parameter int DEPTH = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic       pop,
  input  logic       clr,
  input  logic [6:0] din,
  output logic [6:0] top,
  output logic       empty,
  output logic       full
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] ONE = (AW+1)'(1);

  logic [AW:0]   cnt_q, cnt_d;
  logic [6:0]    mem_q [DEPTH];
  logic [AW-1:0] top_idx;

  // DEPTH is a power of two, so the wrap at full lands on DEPTH-1.
  assign top_idx = cnt_q[AW-1:0] - AW'(1);
  assign top     = mem_q[top_idx];
  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == (AW+1)'(DEPTH));

  always_comb begin
    cnt_d = cnt_q;
    if (clr)                cnt_d = '0;
    else if (push && !full) cnt_d = cnt_q + ONE;
    else if (pop && !empty) cnt_d = cnt_q - ONE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  always_ff @(posedge clk) begin
    if (push && !full && !clr) mem_q[cnt_q[AW-1:0]] <= din;
  end
endmodule

// File: rtl/infix_to_postfix.sv
// Shunting-yard converter: infix ASCII characters in, postfix tokens out.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : character/token handshake (slave side)
//
// state     | meaning
// IDLE      | req high, waiting for a character
// DECODE    | classify the latched character
// EMIT_OPND | emit the latched digit
// POP_OPS   | pop/emit operators of higher-or-equal precedence
// PUSH      | push the incoming operator
// CLOSE     | pop/emit up to the matching '(' and drop it
// FLUSH     | pop/emit everything on '='
// EMIT_END  | emit '=' (or ERR_TOK after an error)
// DRAIN_ERR | swallow characters until '='
module infix_to_postfix
  import infix_to_postfix_pkg::*;
#(
  parameter int         STACK_DEPTH = 16,
  parameter logic [6:0] ERR_TOK     = ERR_TOK_DEFAULT
) (
  input logic                 clk,
  input logic                 rst,
  infix_to_postfix_if.slave   bus
);
  state_t     state_q, state_d;
  logic [6:0] char_q, char_d;
  logic       req_q, req_d;
  logic       err_q, err_d;
  logic       gap_q, gap_d;

  logic       stk_push, stk_pop, stk_clr;
  logic [6:0] stk_top;
  logic       stk_empty, stk_full;

  logic       accept, can_emit, is_digit, is_op, fault, emit;
  logic [6:0] emit_val;

  infix_to_postfix_op_stack #(.DEPTH(STACK_DEPTH)) u_stack (
    .clk   (clk),
    .rst   (rst),
    .push  (stk_push),
    .pop   (stk_pop),
    .clr   (stk_clr),
    .din   (char_q),
    .top   (stk_top),
    .empty (stk_empty),
    .full  (stk_full)
  );

  assign accept   = bus.en && req_q;
  // gap_q forces one idle cycle between consecutive tokens.
  assign can_emit = bus.tok_req && !gap_q;
  assign is_digit = (char_q >= CH_0) && (char_q <= CH_9);
  assign is_op    = (char_q == CH_PLUS) || (char_q == CH_MINUS) || (char_q == CH_MUL);

  always_comb begin
    state_d  = state_q;
    char_d   = char_q;
    err_d    = err_q;
    stk_push = 1'b0;
    stk_pop  = 1'b0;
    stk_clr  = 1'b0;
    fault    = 1'b0;
    emit     = 1'b0;
    emit_val = 7'h00;

    case (state_q)
      IDLE: begin
        if (accept) begin
          char_d  = bus.variable;
          state_d = DECODE;
        end
      end
      DECODE: begin
        if (is_digit)               state_d = EMIT_OPND;
        else if (is_op)             state_d = POP_OPS;
        else if (char_q == CH_RP)   state_d = CLOSE;
        else if (char_q == CH_EQ)   state_d = FLUSH;
        else if (char_q == CH_LP) begin
          if (stk_full) fault = 1'b1;
          else begin
            stk_push = 1'b1;
            state_d  = IDLE;
          end
        end else                    fault = 1'b1;
      end
      EMIT_OPND: begin
        if (can_emit) begin
          emit     = 1'b1;
          emit_val = char_q;
          state_d  = IDLE;
        end
      end
      POP_OPS: begin
        if (!stk_empty && stk_top != CH_LP && prec(stk_top) >= prec(char_q)) begin
          if (can_emit) begin
            emit     = 1'b1;
            emit_val = stk_top;
            stk_pop  = 1'b1;
          end
        end else state_d = PUSH;
      end
      PUSH: begin
        if (stk_full) fault = 1'b1;
        else begin
          stk_push = 1'b1;
          state_d  = IDLE;
        end
      end
      CLOSE: begin
        if (stk_empty) fault = 1'b1;
        else if (stk_top == CH_LP) begin
          stk_pop = 1'b1;
          state_d = IDLE;
        end else if (can_emit) begin
          emit     = 1'b1;
          emit_val = stk_top;
          stk_pop  = 1'b1;
        end
      end
      FLUSH: begin
        if (stk_empty)               state_d = EMIT_END;
        else if (stk_top == CH_LP)   fault = 1'b1;
        else if (can_emit) begin
          emit     = 1'b1;
          emit_val = stk_top;
          stk_pop  = 1'b1;
        end
      end
      EMIT_END: begin
        if (can_emit) begin
          emit     = 1'b1;
          emit_val = err_q ? ERR_TOK : CH_EQ;
          err_d    = 1'b0;
          state_d  = IDLE;
        end
      end
      DRAIN_ERR: begin
        if (accept && bus.variable == CH_EQ) begin
          stk_clr = 1'b1;
          state_d = EMIT_END;
        end
      end
      default: state_d = IDLE;
    endcase

    // An error overrides any pending pop/emit decision of this cycle.
    if (fault) begin
      emit     = 1'b0;
      emit_val = 7'h00;
      stk_pop  = 1'b0;
      err_d    = 1'b1;
      state_d  = DRAIN_ERR;
    end

    // Drop req for one cycle after each swallowed character as well.
    req_d = (state_d == IDLE) ||
            (state_d == DRAIN_ERR && !(state_q == DRAIN_ERR && accept));
    gap_d = emit;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      char_q  <= 7'h00;
      req_q   <= 1'b0;
      err_q   <= 1'b0;
      gap_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      char_q  <= char_d;
      req_q   <= req_d;
      err_q   <= err_d;
      gap_q   <= gap_d;
    end
  end

  assign bus.req    = req_q;
  assign bus.tok_en = emit;
  assign bus.tok    = emit_val;
  assign bus.err    = err_q;
endmodule

// File: tb/tb_infix_to_postfix.sv
module tb_infix_to_postfix;
  import infix_to_postfix_pkg::*;

  localparam logic [6:0] ERR_T = 7'h7F;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  infix_to_postfix_if bus();

  infix_to_postfix #(.STACK_DEPTH(16), .ERR_TOK(ERR_T)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    string in_s;
    string exp_s;
  } vec_t;

  vec_t       vecs[7];
  int         n_checks = 0;
  int         n_fail   = 0;
  logic [6:0] exp_q[$];
  logic [6:0] mon_exp;
  logic       prev_tok_en = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: every token the DUT strobes must be the next expected one.
  always @(negedge clk) begin
    if (bus.tok_en === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_tok: got %0h expected no token", bus.tok);
      end else begin
        mon_exp = exp_q.pop_front();
        check("tok", int'(bus.tok), int'(mon_exp));
      end
      check("tok_en_gap", int'(prev_tok_en), 0);
    end
    prev_tok_en = bus.tok_en;
  end

  // '!' in an expected string stands for ERR_TOK.
  task automatic push_exp(input string s);
    byte b;
    for (int i = 0; i < s.len(); i++) begin
      b = s[i];
      exp_q.push_back(b == "!" ? ERR_T : b[6:0]);
    end
  endtask

  task automatic send_char(input logic [6:0] c);
    int n = 0;
    while (bus.req !== 1'b1 && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    check("req_ready", int'(bus.req), 1);
    bus.en = 1'b1;
    bus.variable = c;
    @(posedge clk); #1;
    bus.en = 1'b0;
    bus.variable = 7'h00;
  endtask

  task automatic send_str(input string s);
    byte b;
    for (int i = 0; i < s.len(); i++) begin
      b = s[i];
      send_char(b[6:0]);
    end
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain", exp_q.size(), 0);
  endtask

  task automatic idle_cycles(input int k);
    repeat (k) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int stall_tok, stall_req;

    vecs[0] = '{in_s: "3+4=",       exp_s: "34+="};
    vecs[1] = '{in_s: "2+3*4=",     exp_s: "234*+="};
    vecs[2] = '{in_s: "2*3+4=",     exp_s: "23*4+="};
    vecs[3] = '{in_s: "(1+2)*3=",   exp_s: "12+3*="};
    vecs[4] = '{in_s: "8-3-2=",     exp_s: "83-2-="};
    vecs[5] = '{in_s: "9*(8-7)*6=", exp_s: "987-*6*="};
    vecs[6] = '{in_s: "5=",         exp_s: "5="};

    rst = 1'b1;
    bus.en = 1'b0;
    bus.variable = 7'h00;
    bus.tok_req = 1'b1;
    idle_cycles(3);
    @(negedge clk);
    check("rst_req", int'(bus.req), 0);
    check("rst_tok_en", int'(bus.tok_en), 0);
    check("rst_tok", int'(bus.tok), 0);
    check("rst_err", int'(bus.err), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check("req_after_rst", int'(bus.req), 1);

    // Digit latency: tok_en two cycles after the en cycle.
    push_exp("7=");
    send_char(7'h37);
    @(negedge clk);
    check("lat_cycle1", int'(bus.tok_en), 0);
    @(negedge clk);
    check("lat_cycle2", int'(bus.tok_en), 1);
    @(posedge clk); #1;
    send_char(CH_EQ);
    wait_drain();

    for (int v = 0; v < 7; v++) begin
      push_exp(vecs[v].exp_s);
      send_str(vecs[v].in_s);
      wait_drain();
      check("err_clean", int'(bus.err), 0);
    end

    // Downstream stall after the first token.
    push_exp("34+=");
    send_char(7'h33);
    begin
      int n = 0;
      while (exp_q.size() != 3 && n < 50) begin
        @(posedge clk); #1;
        n++;
      end
    end
    check("stall_first_tok", exp_q.size(), 3);
    bus.tok_req = 1'b0;
    send_char(CH_PLUS);
    send_char(7'h34);
    stall_tok = 0;
    stall_req = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.tok_en === 1'b1) stall_tok++;
      if (bus.req === 1'b1) stall_req++;
    end
    @(posedge clk); #1;
    check("stall_no_tok", stall_tok, 0);
    check("stall_req_low", stall_req, 0);
    check("stall_pending", exp_q.size(), 3);
    bus.tok_req = 1'b1;
    send_char(CH_EQ);
    wait_drain();

    // Unmatched ')'.
    push_exp("1!");
    send_str("1)");
    idle_cycles(5);
    check("rp_err_set", int'(bus.err), 1);
    send_str("+2");
    idle_cycles(3);
    check("rp_absorbed", exp_q.size(), 1);
    check("rp_err_held", int'(bus.err), 1);
    send_char(CH_EQ);
    wait_drain();
    check("rp_err_clr", int'(bus.err), 0);
    push_exp("5=");
    send_str("5=");
    wait_drain();

    // Stack overflow: 16 '(' fit, the 17th does not.
    push_exp("!");
    repeat (16) send_char(CH_LP);
    idle_cycles(4);
    check("full_no_err", int'(bus.err), 0);
    send_char(CH_LP);
    idle_cycles(4);
    check("ovf_err", int'(bus.err), 1);
    send_char(CH_EQ);
    wait_drain();
    check("ovf_err_clr", int'(bus.err), 0);

    // Reset mid-expression.
    push_exp("4");
    send_str("4+(");
    wait_drain();
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_req", int'(bus.req), 0);
    check("mid_rst_tok_en", int'(bus.tok_en), 0);
    check("mid_rst_tok", int'(bus.tok), 0);
    check("mid_rst_err", int'(bus.err), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    push_exp("6=");
    send_str("6=");
    wait_drain();
    check("post_rst_err", int'(bus.err), 0);

    idle_cycles(5);
    check("no_leftover", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
